// File: rtl/vram_arbiter.sv
// VRAM port arbiter: VDP, auxiliary requester and refresh timer share one SDRAM controller port.
// Build option VRAM_ARB_STATS_EN adds per-class grant counters (stat_vdp, stat_aux, stat_ref).
module vram_arbiter #(
  parameter int unsigned REFRESH_INTERVAL = 780,
  parameter int unsigned BUSY_TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vdp_slot,
  input  logic        vdp_idle,
  input  logic        vdp_we_n,
  input  logic [16:0] vdp_adr,
  input  logic [7:0]  vdp_dbo,
  output logic [15:0] vdp_rdata,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [16:0] aux_adr,
  input  logic [7:0]  aux_din,
  output logic        aux_ack,
  output logic [15:0] aux_rdata,
  output logic        mc_read,
  output logic        mc_write,
  output logic        mc_refresh,
  output logic [20:0] mc_addr,
  output logic [15:0] mc_din,
  output logic [1:0]  mc_wdm,
  input  logic [15:0] mc_dout,
  input  logic        mc_busy,
  output logic        refresh_miss,
  output logic        vdp_overrun,
  output logic        timeout_err
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0] stat_vdp,
  output logic [15:0] stat_aux,
  output logic [15:0] stat_ref
`endif
);

  localparam int unsigned REF_MAX = 2 * REFRESH_INTERVAL;
  localparam int unsigned RCW     = $clog2(REF_MAX + 1);
  localparam int unsigned TCW     = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO, DONE} state_t;
  typedef enum logic [1:0] {SRC_VDP, SRC_AUX, SRC_REF} src_t;

  state_t           state;
  src_t             src;
  logic             src_rd;
  logic             slot_q, pend, pend_we_n;
  logic [16:0]      pend_adr;
  logic [7:0]       pend_dbo;
  logic [RCW-1:0]   ref_cnt;
  logic [TCW-1:0]   tmo_cnt;

  logic             slot_edge, vdp_want, sel_we_n;
  logic [16:0]      sel_adr, g_adr;
  logic [7:0]       sel_dbo, g_d;
  logic             ref_due, ref_opt, can_grant;
  logic             grant_vdp, grant_ref, grant_aux, g_rd;
  logic             waiting, busy_done, fin_tmo, finish;

  // A slot edge arriving this cycle competes directly, so it wins over a simultaneous aux request.
  always_comb begin
    slot_edge = vdp_slot & ~slot_q;
    vdp_want  = pend | slot_edge;
    sel_we_n  = slot_edge ? vdp_we_n : pend_we_n;
    sel_adr   = slot_edge ? vdp_adr  : pend_adr;
    sel_dbo   = slot_edge ? vdp_dbo  : pend_dbo;
    ref_due   = ref_cnt >= RCW'(REFRESH_INTERVAL);
    ref_opt   = vdp_idle & (ref_cnt >= RCW'(REFRESH_INTERVAL / 2));
    can_grant = (state == IDLE) & ~mc_busy;
    grant_vdp = can_grant & vdp_want;
    grant_ref = can_grant & ~vdp_want & (ref_due | (~aux_req & ref_opt));
    grant_aux = can_grant & ~vdp_want & ~ref_due & aux_req;
    g_adr     = grant_vdp ? sel_adr : aux_adr;
    g_d       = grant_vdp ? sel_dbo : aux_din;
    g_rd      = grant_vdp ? sel_we_n : ~aux_we;
    waiting   = (state == WAIT_HI) | (state == WAIT_LO);
    busy_done = (state == WAIT_LO) & ~mc_busy;
    fin_tmo   = waiting & ~busy_done & (tmo_cnt == TCW'(BUSY_TIMEOUT - 1));
    finish    = busy_done | fin_tmo;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      src          <= SRC_VDP;
      src_rd       <= 1'b0;
      slot_q       <= 1'b0;
      pend         <= 1'b0;
      pend_we_n    <= 1'b0;
      pend_adr     <= '0;
      pend_dbo     <= '0;
      ref_cnt      <= '0;
      tmo_cnt      <= '0;
      mc_read      <= 1'b0;
      mc_write     <= 1'b0;
      mc_refresh   <= 1'b0;
      mc_addr      <= '0;
      mc_din       <= '0;
      mc_wdm       <= '0;
      aux_ack      <= 1'b0;
      aux_rdata    <= '0;
      vdp_rdata    <= '0;
      refresh_miss <= 1'b0;
      vdp_overrun  <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      slot_q     <= vdp_slot;
      mc_read    <= 1'b0;
      mc_write   <= 1'b0;
      mc_refresh <= 1'b0;
      aux_ack    <= 1'b0;

      if (slot_edge) begin
        if (pend) vdp_overrun <= 1'b1;
        pend_we_n <= vdp_we_n;
        pend_adr  <= vdp_adr;
        pend_dbo  <= vdp_dbo;
      end
      if (grant_vdp) pend <= 1'b0;
      else if (slot_edge) pend <= 1'b1;

      if (grant_ref) ref_cnt <= '0;
      else if (ref_cnt != RCW'(REF_MAX)) begin
        ref_cnt <= ref_cnt + 1'b1;
        if (ref_cnt == RCW'(REF_MAX - 1)) refresh_miss <= 1'b1;
      end

      if (waiting) tmo_cnt <= tmo_cnt + 1'b1;

      // Completion results are registered on entry to DONE so they are visible during DONE.
      if (finish) begin
        if (fin_tmo) timeout_err <= 1'b1;
        if (src == SRC_VDP && src_rd && !fin_tmo) vdp_rdata <= mc_dout;
        if (src == SRC_AUX && aux_req) begin
          aux_ack <= 1'b1;
          if (fin_tmo) aux_rdata <= '0;
          else if (src_rd) aux_rdata <= mc_dout;
        end
      end

      case (state)
        IDLE: begin
          if (grant_vdp | grant_aux | grant_ref) begin
            state   <= WAIT_HI;
            tmo_cnt <= '0;
            if (grant_ref) begin
              src        <= SRC_REF;
              src_rd     <= 1'b0;
              mc_refresh <= 1'b1;
              mc_addr    <= '0;
              mc_din     <= '0;
              mc_wdm     <= '0;
            end else begin
              src      <= grant_vdp ? SRC_VDP : SRC_AUX;
              src_rd   <= g_rd;
              mc_read  <= g_rd;
              mc_write <= ~g_rd;
              mc_addr  <= {5'b0, g_adr[15:0]};
              mc_din   <= {g_d, g_d};
              mc_wdm   <= {~g_adr[16], g_adr[16]};
            end
          end
        end
        WAIT_HI: begin
          if (finish) state <= DONE;
          else if (mc_busy) state <= WAIT_LO;
        end
        WAIT_LO: if (finish) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_vdp <= '0;
      stat_aux <= '0;
      stat_ref <= '0;
    end else begin
      if (grant_vdp) stat_vdp <= stat_vdp + 1'b1;
      if (grant_aux) stat_aux <= stat_aux + 1'b1;
      if (grant_ref) stat_ref <= stat_ref + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: behavioural memory_controller model plus a command/ack scoreboard.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vdp_slot = 1'b0, vdp_idle = 1'b0, vdp_we_n = 1'b1;
  logic [16:0] vdp_adr = '0;
  logic [7:0]  vdp_dbo = '0;
  logic [15:0] vdp_rdata;
  logic        aux_req = 1'b0, aux_we = 1'b0;
  logic [16:0] aux_adr = '0;
  logic [7:0]  aux_din = '0;
  logic        aux_ack;
  logic [15:0] aux_rdata;
  logic        mc_read, mc_write, mc_refresh;
  logic [20:0] mc_addr;
  logic [15:0] mc_din;
  logic [1:0]  mc_wdm;
  logic [15:0] mc_dout = '0;
  logic        mc_busy = 1'b0;
  logic        refresh_miss, vdp_overrun, timeout_err;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stat_vdp, stat_aux, stat_ref;
`endif

  always #5 clk = ~clk;

  vram_arbiter #(.REFRESH_INTERVAL(780), .BUSY_TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .vdp_slot(vdp_slot), .vdp_idle(vdp_idle), .vdp_we_n(vdp_we_n),
    .vdp_adr(vdp_adr), .vdp_dbo(vdp_dbo), .vdp_rdata(vdp_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_adr(aux_adr), .aux_din(aux_din),
    .aux_ack(aux_ack), .aux_rdata(aux_rdata),
    .mc_read(mc_read), .mc_write(mc_write), .mc_refresh(mc_refresh),
    .mc_addr(mc_addr), .mc_din(mc_din), .mc_wdm(mc_wdm),
    .mc_dout(mc_dout), .mc_busy(mc_busy),
    .refresh_miss(refresh_miss), .vdp_overrun(vdp_overrun), .timeout_err(timeout_err)
`ifdef VRAM_ARB_STATS_EN
    , .stat_vdp(stat_vdp), .stat_aux(stat_aux), .stat_ref(stat_ref)
`endif
  );

  // Controller model: busy rises m_delay cycles after a strobe and stays up m_len cycles.
  int          m_k = 1000;
  int          m_delay = 1, m_len = 4;
  logic        m_force = 1'b0;
  logic [15:0] m_dout = '0;

  always @(posedge clk) begin
    int kn;
    if (!reset_n) begin
      m_k     <= 1000;
      mc_busy <= 1'b0;
    end else begin
      kn = (mc_read | mc_write | mc_refresh) ? 1 : ((m_k < 1000) ? m_k + 1 : m_k);
      m_k     <= kn;
      mc_busy <= m_force | (kn >= m_delay && kn < m_delay + m_len);
    end
    mc_dout <= m_dout;
  end

  // Cycle index since reset release equals the refresh-counter value the DUT should hold.
  int cyc = 0, strobe_cnt = 0, ack_cnt = 0, multi_cnt = 0;
  always @(posedge clk) begin
    cyc        <= reset_n ? cyc + 1 : 0;
    strobe_cnt <= strobe_cnt + int'(mc_read) + int'(mc_write) + int'(mc_refresh);
    if (int'(mc_read) + int'(mc_write) + int'(mc_refresh) > 1) multi_cnt <= multi_cnt + 1;
    ack_cnt    <= ack_cnt + int'(aux_ack);
  end

  typedef struct packed {
    logic [1:0]  kind;   // 1 read, 2 write, 3 refresh
    logic [20:0] addr;
    logic [15:0] din;
    logic [1:0]  wdm;
  } cmd_t;

  cmd_t        exp_q[$];
  logic [15:0] ack_q[$];
  int          n_cmp = 0, n_bad = 0;

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; vdp_slot = 1'b0; vdp_idle = 1'b0; vdp_we_n = 1'b1; vdp_adr = '0; vdp_dbo = '0;
    aux_req = 1'b0; aux_we = 1'b0; aux_adr = '0; aux_din = '0;
    m_force = 1'b0; m_delay = 1; m_len = 4; m_dout = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    ack_q.delete();
  endtask

  // Captures the next strobe cycle; comparison is left to the caller.
  task automatic wait_strobe(input int bound, output bit ok, output cmd_t c, output int at);
    ok = 1'b0; c = '0; at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (mc_read | mc_write | mc_refresh) begin
        ok = 1'b1; at = cyc;
        c.kind = mc_refresh ? 2'd3 : (mc_write ? 2'd2 : 2'd1);
        c.addr = mc_addr; c.din = mc_din; c.wdm = mc_wdm;
        break;
      end
    end
  endtask

  task automatic wait_ack(input int bound, output bit ok, output int at);
    ok = 1'b0; at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (aux_ack) begin ok = 1'b1; at = cyc; break; end
    end
  endtask

  task automatic test_reset();
    logic [38:0] obs;
    do_reset();
    @(negedge clk);
    obs = {mc_read, mc_write, mc_refresh, aux_ack, vdp_rdata, aux_rdata, refresh_miss, vdp_overrun, timeout_err};
    n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL reset_state: got %h want 0", obs); end
    n_cmp++; if (mc_busy !== 1'b0 || strobe_cnt !== 0) begin n_bad++; $display("FAIL reset_no_strobe: got %0d want 0", strobe_cnt); end
  endtask

  task automatic test_vdp_write();
    cmd_t c, e; bit ok; int at, base; bit stable;
    do_reset();
    base = strobe_cnt;
    @(negedge clk);
    vdp_we_n = 1'b0; vdp_adr = 17'h1_0123; vdp_dbo = 8'hA5; vdp_slot = 1'b1;
    exp_q.push_back('{kind: 2'd2, addr: 21'h000123, din: 16'hA5A5, wdm: 2'b01});
    wait_strobe(20, ok, c, at);
    vdp_slot = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL vdp_write_strobe: got none want one within 20 cycles"); end
    e = exp_q.pop_front();
    n_cmp++; if (c !== e) begin n_bad++; $display("FAIL vdp_write_cmd: got %h want %h", c, e); end
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mc_addr !== e.addr || mc_din !== e.din || mc_wdm !== e.wdm) stable = 1'b0;
    end
    n_cmp++; if (!stable) begin n_bad++; $display("FAIL vdp_write_hold: got unstable want stable fields"); end
    repeat (10) @(negedge clk);
    n_cmp++; if (strobe_cnt - base !== 1) begin n_bad++; $display("FAIL vdp_write_count: got %0d want 1", strobe_cnt - base); end
  endtask

  task automatic test_vdp_read();
    cmd_t c, e; bit ok; int at, lat;
    do_reset();
    m_dout = 16'h1234;
    @(negedge clk);
    vdp_we_n = 1'b1; vdp_adr = 17'h0_0040; vdp_dbo = 8'h00; vdp_slot = 1'b1;
    exp_q.push_back('{kind: 2'd1, addr: 21'h000040, din: 16'h0000, wdm: 2'b10});
    wait_strobe(20, ok, c, at);
    vdp_slot = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if (!ok || c !== e) begin n_bad++; $display("FAIL vdp_read_cmd: got %h want %h", c, e); end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (lat < 0 && vdp_rdata === 16'h1234) lat = i;
    end
    n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL vdp_read_latency: got %0d want 6", lat); end
    n_cmp++; if (vdp_rdata !== 16'h1234) begin n_bad++; $display("FAIL vdp_read_hold: got %h want 1234", vdp_rdata); end
  endtask

  task automatic test_priority();
    cmd_t c, e; bit ok; int at1, at2, at_ack; logic [15:0] er;
    do_reset();
    m_dout = 16'hBEEF;
    @(negedge clk);
    aux_req = 1'b1; aux_we = 1'b0; aux_adr = 17'h0_0200; aux_din = 8'h00;
    vdp_we_n = 1'b0; vdp_adr = 17'h0_0010; vdp_dbo = 8'h3C; vdp_slot = 1'b1;
    exp_q.push_back('{kind: 2'd2, addr: 21'h000010, din: 16'h3C3C, wdm: 2'b10});
    exp_q.push_back('{kind: 2'd1, addr: 21'h000200, din: 16'h0000, wdm: 2'b10});
    ack_q.push_back(16'hBEEF);
    wait_strobe(20, ok, c, at1);
    vdp_slot = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if (!ok || c !== e) begin n_bad++; $display("FAIL prio_first_vdp: got %h want %h", c, e); end
    wait_strobe(30, ok, c, at2);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || c !== e) begin n_bad++; $display("FAIL prio_second_aux: got %h want %h", c, e); end
    n_cmp++; if (at2 - at1 !== 8) begin n_bad++; $display("FAIL prio_aux_gap: got %0d want 8", at2 - at1); end
    wait_ack(20, ok, at_ack);
    aux_req = 1'b0;
    er = ack_q.pop_front();
    n_cmp++; if (!ok || aux_rdata !== er) begin n_bad++; $display("FAIL prio_aux_rdata: got %h want %h", aux_rdata, er); end
    @(negedge clk);
    n_cmp++; if (aux_ack !== 1'b0) begin n_bad++; $display("FAIL prio_ack_pulse: got %b want 0", aux_ack); end
  endtask

  task automatic test_refresh_due();
    cmd_t c, e; bit ok; int at, at_ack;
    do_reset();
    m_force = 1'b1;
    @(negedge clk);
    aux_req = 1'b1; aux_we = 1'b1; aux_adr = 17'h0_0300; aux_din = 8'h77;
    exp_q.push_back('{kind: 2'd3, addr: 21'h0, din: 16'h0, wdm: 2'b00});
    exp_q.push_back('{kind: 2'd2, addr: 21'h000300, din: 16'h7777, wdm: 2'b10});
    ack_q.push_back(16'h0000);
    while (cyc < 779) @(negedge clk);
    m_force = 1'b0;
    wait_strobe(10, ok, c, at);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || c.kind !== e.kind) begin n_bad++; $display("FAIL ref_due_kind: got %0d want %0d", c.kind, e.kind); end
    n_cmp++; if (at !== 781) begin n_bad++; $display("FAIL ref_due_cycle: got %0d want 781", at); end
    wait_strobe(30, ok, c, at);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || c !== e) begin n_bad++; $display("FAIL ref_due_aux_cmd: got %h want %h", c, e); end
    wait_ack(20, ok, at_ack);
    aux_req = 1'b0;
    n_cmp++; if (!ok || aux_rdata !== ack_q[0]) begin n_bad++; $display("FAIL ref_due_aux_ack: got %b/%h want 1/%h", ok, aux_rdata, ack_q[0]); end
    void'(ack_q.pop_front());
    wait_strobe(800, ok, c, at);
    n_cmp++; if (!ok || c.kind !== 2'd3 || at !== 1562) begin n_bad++; $display("FAIL ref_due_next: got kind %0d at %0d want 3 at 1562", c.kind, at); end
    n_cmp++; if (refresh_miss !== 1'b0) begin n_bad++; $display("FAIL ref_due_miss: got %b want 0", refresh_miss); end
  endtask

  task automatic test_refresh_opt();
    cmd_t c; bit ok; int at;
    do_reset();
    while (cyc < 380) @(negedge clk);
    vdp_idle = 1'b1;
    wait_strobe(40, ok, c, at);
    vdp_idle = 1'b0;
    n_cmp++; if (!ok || c.kind !== 2'd3 || at !== 391) begin n_bad++; $display("FAIL ref_opt: got kind %0d at %0d want 3 at 391", c.kind, at); end
    repeat (10) @(negedge clk);
    n_cmp++; if (refresh_miss !== 1'b0) begin n_bad++; $display("FAIL ref_opt_miss: got %b want 0", refresh_miss); end
  endtask

  task automatic test_timeout();
    cmd_t c, e; bit ok; int at, at_ack;
    do_reset();
    m_len = 0; m_dout = 16'hFFFF;
    @(negedge clk);
    aux_req = 1'b1; aux_we = 1'b0; aux_adr = 17'h0_0500; aux_din = 8'h00;
    exp_q.push_back('{kind: 2'd1, addr: 21'h000500, din: 16'h0000, wdm: 2'b10});
    ack_q.push_back(16'h0000);
    wait_strobe(10, ok, c, at);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || c !== e) begin n_bad++; $display("FAIL tmo_cmd: got %h want %h", c, e); end
    wait_ack(100, ok, at_ack);
    aux_req = 1'b0;
    n_cmp++; if (!ok || at_ack - at !== 64) begin n_bad++; $display("FAIL tmo_latency: got %0d want 64", at_ack - at); end
    n_cmp++; if (aux_rdata !== ack_q[0]) begin n_bad++; $display("FAIL tmo_rdata: got %h want %h", aux_rdata, ack_q[0]); end
    void'(ack_q.pop_front());
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL tmo_flag: got %b want 1", timeout_err); end
    m_len = 4; m_dout = 16'h5A5A;
    @(negedge clk);
    vdp_we_n = 1'b1; vdp_adr = 17'h0_0001; vdp_slot = 1'b1;
    exp_q.push_back('{kind: 2'd1, addr: 21'h000001, din: 16'h0000, wdm: 2'b10});
    wait_strobe(20, ok, c, at);
    vdp_slot = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if (!ok || c !== e) begin n_bad++; $display("FAIL tmo_recover_cmd: got %h want %h", c, e); end
    repeat (10) @(negedge clk);
    n_cmp++; if (vdp_rdata !== 16'h5A5A) begin n_bad++; $display("FAIL tmo_recover_rdata: got %h want 5a5a", vdp_rdata); end
  endtask

  task automatic test_overrun();
    cmd_t c, e; bit ok; int at, base;
    do_reset();
    base = strobe_cnt;
    m_force = 1'b1;
    @(negedge clk);
    vdp_we_n = 1'b0; vdp_adr = 17'h0_0111; vdp_dbo = 8'h11; vdp_slot = 1'b1;
    repeat (2) @(negedge clk);
    vdp_slot = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (vdp_overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_first: got %b want 0", vdp_overrun); end
    vdp_adr = 17'h1_0222; vdp_dbo = 8'h22; vdp_slot = 1'b1;
    @(negedge clk);
    vdp_slot = 1'b0;
    n_cmp++; if (vdp_overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_second: got %b want 1", vdp_overrun); end
    n_cmp++; if (strobe_cnt - base !== 0) begin n_bad++; $display("FAIL overrun_busy_hold: got %0d want 0", strobe_cnt - base); end
    exp_q.push_back('{kind: 2'd2, addr: 21'h000222, din: 16'h2222, wdm: 2'b01});
    m_force = 1'b0;
    wait_strobe(10, ok, c, at);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || c !== e) begin n_bad++; $display("FAIL overrun_cmd: got %h want %h", c, e); end
    repeat (12) @(negedge clk);
    n_cmp++; if (strobe_cnt - base !== 1) begin n_bad++; $display("FAIL overrun_count: got %0d want 1", strobe_cnt - base); end
  endtask

  task automatic test_aux_drop();
    cmd_t c, e; bit ok; int at, base;
    do_reset();
    m_dout = 16'h0F0F;
    @(negedge clk);
    aux_req = 1'b1; aux_we = 1'b0; aux_adr = 17'h0_0600;
    exp_q.push_back('{kind: 2'd1, addr: 21'h000600, din: 16'h0000, wdm: 2'b10});
    wait_strobe(10, ok, c, at);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || c !== e) begin n_bad++; $display("FAIL drop_cmd: got %h want %h", c, e); end
    base = ack_cnt;
    @(negedge clk);
    aux_req = 1'b0;
    repeat (15) @(negedge clk);
    n_cmp++; if (ack_cnt - base !== 0 || aux_rdata !== 16'h0000) begin n_bad++; $display("FAIL drop_no_ack: got %0d/%h want 0/0000", ack_cnt - base, aux_rdata); end
  endtask

  task automatic test_reset_abort();
    cmd_t c; bit ok; int at;
    logic [38:0] obs;
    do_reset();
    m_dout = 16'hCAFE;
    @(negedge clk);
    vdp_we_n = 1'b1; vdp_adr = 17'h0_0002; vdp_slot = 1'b1;
    wait_strobe(10, ok, c, at);
    vdp_slot = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if (vdp_rdata !== 16'hCAFE) begin n_bad++; $display("FAIL abort_pre_rdata: got %h want cafe", vdp_rdata); end
    aux_req = 1'b1; aux_we = 1'b0; aux_adr = 17'h0_0003;
    wait_strobe(10, ok, c, at);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    obs = {mc_read, mc_write, mc_refresh, aux_ack, vdp_rdata, aux_rdata, refresh_miss, vdp_overrun, timeout_err};
    n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL abort_state: got %h want 0", obs); end
    aux_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vdp_write();
    test_vdp_read();
    test_priority();
    test_refresh_due();
    test_refresh_opt();
    test_timeout();
    test_overrun();
    test_aux_drop();
    test_reset_abort();
    n_cmp++; if (multi_cnt !== 0) begin n_bad++; $display("FAIL strobe_onehot: got %0d want 0", multi_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
